mem_wb_pipe_stage: RTL and testbench
====================================

// Module: mem_wb_pipe_stage
// PURPOSE
// - Parametrised MEM->WB pipeline stage with a valid/ready handshake.
// - Contains a 2-entry skid buffer, so a WB-side stall never drops a MEM result.
// - Supports a synchronous flush.
// - Provides a registered forwarding tap, so EX-stage bypass logic can consume the WB-stage result.
// - Sits between the data-memory stage and the register-file write port.
// PARAMETERS
// - DATA_W        32  width of read data and ALU result
// - REG_W          5  register-address width
// - CTRL_W         2  WB control-bundle width
// - REGWRITE_BIT   1  index of RegWrite within the ctrl bundle
// - MEMTOREG_BIT   0  index of MemtoReg within the ctrl bundle
// PORTS
// - clk            in   1       clock, all state updates on posedge
// - reset          in   1       synchronous, active-high
// - flush          in   1       synchronous: discard all held entries
// - in_valid       in   1       MEM stage presents a result
// - in_ready       out  1       stage can accept this cycle
// - in_ctrl_wb     in   CTRL_W  WB control bundle
// - in_read_data   in   DATA_W  data-memory read data
// - in_alu_result  in   DATA_W  ALU result
// - in_write_reg   in   REG_W   destination register
// - out_valid      out  1       WB entry valid
// - out_ready      in   1       WB consumes the entry this cycle
// - out_ctrl_wb    out  CTRL_W  ctrl bundle, forced to 0 when !out_valid
// - out_read_data  out  DATA_W  held read data
// - out_alu_result out  DATA_W  held ALU result
// - out_write_reg  out  REG_W   held destination register
// - fwd_valid      out  1       out_valid & ctrl[REGWRITE_BIT] & (out_write_reg!=0)
// - fwd_reg        out  REG_W   equals out_write_reg
// - fwd_data       out  DATA_W  ctrl[MEMTOREG_BIT] ? out_read_data : out_alu_result
// BEHAVIOUR
// - Reset: state EMPTY; main and skid payloads are all zero.
//   - Outputs after reset: in_ready=1, out_valid=0, all out_*=0, fwd_valid=0.
// - Latency: an input accepted at edge N is visible at the outputs after edge N (1 cycle).
// - Handshakes:
//   - Input transfer = in_valid & in_ready.
//   - Output transfer = out_valid & out_ready.
//   - in_ready is a register output: in_ready = (state != FULL).
//   - No combinational path from out_ready to in_ready.
// - States and transitions (evaluated each edge):
//   - EMPTY: in_valid -> ONE, main <= input.
//   - ONE:
//     - in_valid & out_ready   -> ONE, main <= input (pass-through at full rate).
//     - in_valid & !out_ready  -> FULL, skid <= input, main held.
//     - !in_valid & out_ready  -> EMPTY.
//     - otherwise hold.
//   - FULL:
//     - out_ready -> ONE, main <= skid.
//     - Inputs are ignored because in_ready=0.
//     - !out_ready: hold.
// - Flush:
//   - -> EMPTY next edge, overriding any simultaneous input or output transfer.
//   - Payload registers need not clear, but out_ctrl_wb reads 0 because it is gated by valid.
// - Priority: reset > flush > handshake.
//   - A reset asserted mid-stall (FULL) discards both entries.
// - Payloads are held unchanged while !out_ready (stable-while-valid rule).
// - A bubble (out_valid=0) never asserts RegWrite at WB.
// - fwd_*, out_ctrl_wb gating and fwd_valid are derived combinationally from the main entry only.
//   - The skid entry is never forwarded; EX stalls on it through the in_ready back-pressure.
// - Widths: fwd_data is exactly DATA_W; there is no sign extension.
//   - fwd_valid=0 for register 0 even when RegWrite=1.
// STRUCTURE
// - Shared package/header `pipe_pkg`:
//   - state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
//   - default ctrl bit indices REGWRITE_BIT and MEMTOREG_BIT.
// - One sub-module, `pipe_skid_buffer #(PAYLOAD_W)`:
//   - generic 2-entry valid/ready skid buffer plus flush;
//   - payload = {ctrl, read_data, alu_result, write_reg}.
// - The top level adds valid gating of ctrl and the forwarding mux.
// - Both sub-module and top level must be reusable for the IF/ID, ID/EX and EX/MEM stages.
// TESTING
// 1. Reset with in_valid=1, then release.
//    - While reset is asserted: out_valid=0, in_ready=1, all out_*=0.
//    - First accept occurs on the edge after deassertion.
// 2. Stream 4 entries with out_ready=1 (alu=0x10..0x13, reg=1..4, ctrl=2'b10).
//    - Each appears one cycle later at full rate.
//    - fwd_data=alu and fwd_valid=1 for each.
// 3. Entry A accepted, out_ready=0, then entry B.
//    - State goes FULL, in_ready=0, and A is held.
//    - Entry C offered while FULL is not taken.
//    - Raise out_ready: A then B drain, in order, with nothing lost.
// 4. Flush while FULL, with in_valid=1 on the same edge.
//    - Next cycle: out_valid=0, out_ctrl_wb=0, fwd_valid=0, in_ready=1.
//    - The flushed entries and the offered input never appear.
// 5. Forwarding cases:
//    - ctrl=2'b11, rd=0xDEAD, alu=0xBEEF, reg=7 -> fwd_data=0xDEAD, fwd_valid=1.
//    - Same with reg=0 -> fwd_valid=0.
//    - ctrl=2'b01 -> fwd_valid=0.
// 6. Reset asserted mid-stall (FULL) -> next cycle EMPTY, out_valid=0, in_ready=1, all outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  // Occupancy of a 2-entry skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Default positions of the WB control bits inside the ctrl bundle
  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// The main entry drives the outputs; the skid entry catches the one
// transfer that arrives while the consumer is stalling. in_ready is
// registered so there is no combinational path from out_ready to in_ready.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  skid_state_e          state_q;
  skid_state_e          state_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;

  // Next-state and payload-load decisions; flush overrides every transfer
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_valid) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so any offered input is simply not taken
        if (out_ready) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Occupancy state plus the handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Payload entries; held unchanged unless a transfer loads them
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_payload;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_payload;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_payload = main_q;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and a forwarding tap for EX-stage bypass.
// Only the main entry is forwarded; EX stalls on the skid entry via in_ready.
module mem_wb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int CTRL_W       = 2,
  parameter int REGWRITE_BIT = pipe_pkg::REGWRITE_BIT,
  parameter int MEMTOREG_BIT = pipe_pkg::MEMTOREG_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl_wb,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl_wb,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PAYLOAD_W = CTRL_W + 2 * DATA_W + REG_W;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] held_payload;
  logic [CTRL_W-1:0]    held_ctrl;
  logic [CTRL_W-1:0]    gated_ctrl;

  assign in_payload = {in_ctrl_wb, in_read_data, in_alu_result, in_write_reg};

  pipe_skid_buffer #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(held_payload)
  );

  assign {held_ctrl, out_read_data, out_alu_result, out_write_reg} = held_payload;

  // Bubbles carry an all-zero ctrl bundle so they can never write the register file
  always_comb begin
    gated_ctrl = out_valid ? held_ctrl : '0;
  end

  // Forwarding tap: r0 is never forwarded, data width is passed through unextended
  always_comb begin
    fwd_valid = gated_ctrl[REGWRITE_BIT] && (out_write_reg != '0);
    fwd_data  = gated_ctrl[MEMTOREG_BIT] ? out_read_data : out_alu_result;
  end

  assign out_ctrl_wb = gated_ctrl;
  assign fwd_reg     = out_write_reg;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Self-checking bench for mem_wb_pipe_stage: queue scoreboard of accepted
// entries, a table of forwarding vectors, and hand-written stall/flush/reset sequences.
module tb_mem_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ctrl_wb;
  logic [31:0] in_read_data;
  logic [31:0] in_alu_result;
  logic [4:0]  in_write_reg;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ctrl_wb;
  logic [31:0] out_read_data;
  logic [31:0] out_alu_result;
  logic [4:0]  out_write_reg;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rg;
  } ent_t;

  ent_t sb[$];

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rg;
    logic [31:0] exp_fwd_data;
    logic        exp_fwd_valid;
  } fwd_vec_t;

  fwd_vec_t fvec [5];

  mem_wb_pipe_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl_wb    (in_ctrl_wb),
    .in_read_data  (in_read_data),
    .in_alu_result (in_alu_result),
    .in_write_reg  (in_write_reg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl_wb   (out_ctrl_wb),
    .out_read_data (out_read_data),
    .out_alu_result(out_alu_result),
    .out_write_reg (out_write_reg),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] rg);
    in_valid      = v;
    in_ctrl_wb    = c;
    in_read_data  = rd;
    in_alu_result = alu;
    in_write_reg  = rg;
  endtask

  // Called at a negedge: compare against the scoreboard head, then advance the model
  task automatic model_step();
    ent_t e;
    logic mv;
    logic mr;
    mv = (sb.size() != 0);
    mr = (sb.size() < 2);
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(mr));
      chk("out_valid", 64'(out_valid), 64'(mv));
      if (mv) begin
        e = sb[0];
        chk("out_ctrl_wb", 64'(out_ctrl_wb), 64'(e.ctrl));
        chk("out_read_data", 64'(out_read_data), 64'(e.rd));
        chk("out_alu_result", 64'(out_alu_result), 64'(e.alu));
        chk("out_write_reg", 64'(out_write_reg), 64'(e.rg));
        chk("fwd_valid", 64'(fwd_valid), 64'(e.ctrl[1] && (e.rg != 5'd0)));
        chk("fwd_reg", 64'(fwd_reg), 64'(e.rg));
        chk("fwd_data", 64'(fwd_data), 64'(e.ctrl[0] ? e.rd : e.alu));
      end else begin
        chk("bubble_ctrl", 64'(out_ctrl_wb), 64'(0));
        chk("bubble_fwd_valid", 64'(fwd_valid), 64'(0));
      end
    end
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (mv && out_ready) void'(sb.pop_front());
      if (mr && in_valid) sb.push_back('{in_ctrl_wb, in_read_data, in_alu_result, in_write_reg});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // All outputs must read as the reset values
  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_ctrl"}, 64'(out_ctrl_wb), 64'(0));
    chk({tag, "_rd"}, 64'(out_read_data), 64'(0));
    chk({tag, "_alu"}, 64'(out_alu_result), 64'(0));
    chk({tag, "_reg"}, 64'(out_write_reg), 64'(0));
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(0));
    chk({tag, "_fwd_reg"}, 64'(fwd_reg), 64'(0));
    chk({tag, "_fwd_data"}, 64'(fwd_data), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    fvec[0] = '{2'b11, 32'hDEAD, 32'hBEEF, 5'd7, 32'hDEAD, 1'b1};
    fvec[1] = '{2'b11, 32'hDEAD, 32'hBEEF, 5'd0, 32'hDEAD, 1'b0};
    fvec[2] = '{2'b01, 32'hDEAD, 32'hBEEF, 5'd7, 32'hDEAD, 1'b0};
    fvec[3] = '{2'b10, 32'hDEAD, 32'hBEEF, 5'd9, 32'hBEEF, 1'b1};
    fvec[4] = '{2'b00, 32'h1234, 32'h5678, 5'd3, 32'h5678, 1'b0};

    // Reset held with in_valid=1: nothing may be accepted
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'hAAAA, 32'h55, 5'd9);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    chk_zero("rst2");

    // Release: first accept on the edge after deassertion, then a full-rate stream
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 32'h0, 32'h10 + 32'(i), 5'(i + 1));
      cycle();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (2) cycle();

    // Stall: A then B fill the buffer, C is refused, then A and B drain in order
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h0, 32'hA0, 5'd10);
    cycle();
    drive(1'b1, 2'b11, 32'hB1, 32'hB0, 5'd11);
    cycle();
    drive(1'b1, 2'b10, 32'h0, 32'hC0, 5'd12);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_holds_A", 64'(out_alu_result), 64'(32'hA0));
    model_step();
    @(posedge clk);
    #1;
    cycle();
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (4) cycle();

    // Flush while FULL with an input offered on the same edge
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h0, 32'hE0, 5'd13);
    cycle();
    drive(1'b1, 2'b10, 32'h0, 32'hE1, 5'd14);
    cycle();
    flush = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'hE2, 5'd15);
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_ctrl", 64'(out_ctrl_wb), 64'(0));
    chk("flush_fwd_valid", 64'(fwd_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    model_step();
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Forwarding vectors, one entry at a time
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, fvec[i].ctrl, fvec[i].rd, fvec[i].alu, fvec[i].rg);
      cycle();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_fwd_data", i), 64'(fwd_data), 64'(fvec[i].exp_fwd_data));
      chk($sformatf("vec%0d_fwd_valid", i), 64'(fwd_valid), 64'(fvec[i].exp_fwd_valid));
      model_step();
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-stall discards both entries
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h77, 32'h66, 5'd5);
    cycle();
    drive(1'b1, 2'b11, 32'h88, 32'h99, 5'd6);
    cycle();
    reset = 1'b1;
    cycle();
    chk_zero("rst_mid");
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
